ps2_cmd_sched: RTL and testbench

Command scheduler between the SMC register logic and the PS2 keyboard host. It shares the single keyboard TX path between two requesters: the I2C host (SMC registers 0x19/0x1A) and the built-in post-BAT init sequence (0xED 0x00). For each command it issues the enqueue pulses to `ps2_kbd_host`, then tracks `kbd_stat` until ACK, ERR or timeout, retrying on failure. Placement: inside `smc`, driving the keyboard host's command inputs in place of direct register writes.

---
 rtl/ps2_cmd_sched_pkg.sv | 40 ++++
 rtl/ps2_cmd_sched_us_timeout.sv | 31 +++
 rtl/ps2_cmd_sched.sv | 182 ++++++++++++++++++
 tb/tb_ps2_cmd_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_cmd_sched_pkg.sv
// Shared PS2/SMC definitions for the keyboard command scheduler:
// status codes, command bytes, register numbers and FSM encodings.
package ps2_cmd_sched_pkg;

    localparam logic [7:0] STAT_IDLE = 8'h00;
    localparam logic [7:0] STAT_BUSY = 8'h01;
    localparam logic [7:0] STAT_ACK  = 8'hFA;
    localparam logic [7:0] STAT_ERR  = 8'hFE;
    localparam logic [7:0] STAT_TMO  = 8'hFF;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_LEDS_OFF     = 8'h00;

    localparam logic [7:0] SMC_REG_KBD_CMD  = 8'h19;
    localparam logic [7:0] SMC_REG_KBD_DATA = 8'h1A;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE1     = 3'd1,
        ST_ISSUE2     = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_REPLY = 3'd4,
        ST_FINISH     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RES_OK  = 2'd0,
        RES_ERR = 2'd1,
        RES_TMO = 2'd2
    } res_t;

    function automatic logic [7:0] final_stat(input res_t r);
        case (r)
            RES_OK:  final_stat = STAT_ACK;
            RES_ERR: final_stat = STAT_ERR;
            default: final_stat = STAT_TMO;
        endcase
    endfunction

endpackage

// File: rtl/ps2_cmd_sched_us_timeout.sv
// Microsecond timeout counter: counts ck1us pulses while enabled,
// saturates at TIMEOUT_US and flags expiry until cleared.
module us_timeout #(
    parameter int TIMEOUT_US = 20000
) (
    input  logic clk6x,
    input  logic reset,
    input  logic ck1us,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_US);

    logic [TW-1:0] count;

    // Clear wins over counting so each wait phase starts from zero.
    always_ff @(posedge clk6x or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && ck1us && (count != LIMIT))
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/ps2_cmd_sched.sv
// Shares the keyboard TX path between the I2C host and the post-BAT LED
// init, issuing enqueue pulses and tracking kbd_stat with retries.
module ps2_cmd_sched
    import ps2_cmd_sched_pkg::*;
#(
    parameter int TIMEOUT_US = 20000,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       ck1us,
    input  logic       host_req_i,
    input  logic       host_len2_i,
    input  logic [7:0] host_cmd_i,
    input  logic [7:0] host_data_i,
    output logic       host_ack_o,
    input  logic       bat_ok_i,
    input  logic [7:0] kbd_stat_i,
    output logic [7:0] kbd_wcmddata_o,
    output logic       kbd_enq_cmd1_o,
    output logic       kbd_enq_cmd2_o,
    output logic [7:0] sched_stat_o,
    output logic       done_o,
    output logic       done_src_o,
    output state_t     dbg_state
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    res_t          res_q, res_d;
    logic [RW-1:0] retry_q;
    logic          init_pend, src_q, len2_q;
    logic [7:0]    cmd_q, data_q;
    logic          grant_init, grant_host, grant;
    logic          src_n, len2_n;
    logic [7:0]    cmd_n, data_n;
    logic          tmo_clear, tmo_enable, tmo_expired;
    logic          retry_due, completes;
    logic [7:0]    wcmddata_d, stat_d;
    logic          enq1_d, enq2_d, ack_d, done_d, done_src_d;

    // Host handshake: host_req_i is a level held until host_ack_o; the ack
    // fires once, in the first ISSUE1 cycle, and a request withdrawn
    // before that is never issued. A pending init always wins the grant.
    assign grant_init = (state_q == ST_IDLE) && (init_pend || bat_ok_i);
    assign grant_host = (state_q == ST_IDLE) && !grant_init && host_req_i;
    assign grant      = grant_init || grant_host;

    assign src_n  = grant ? grant_init : src_q;
    assign len2_n = grant ? (grant_init || host_len2_i) : len2_q;
    assign cmd_n  = grant ? (grant_init ? PS2_CMD_SET_LEDS : host_cmd_i) : cmd_q;
    assign data_n = grant ? (grant_init ? PS2_LEDS_OFF : host_data_i) : data_q;

    assign retry_due = (res_q != RES_OK) && (retry_q < RETRY_LIMIT);
    assign completes = (state_d == ST_FINISH) && (state_q != ST_FINISH) &&
                       !((res_d != RES_OK) && (retry_q < RETRY_LIMIT));

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            res_q     <= RES_OK;
            retry_q   <= '0;
            init_pend <= 1'b0;
            src_q     <= 1'b0;
            len2_q    <= 1'b0;
            cmd_q     <= 8'h00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            init_pend <= grant_init ? 1'b0 : (init_pend || bat_ok_i);
            src_q     <= src_n;
            len2_q    <= len2_n;
            cmd_q     <= cmd_n;
            data_q    <= data_n;
            if (state_q == ST_FINISH)
                retry_q <= retry_due ? retry_q + 1'b1 : '0;
        end
    end

    // A stale ACK/ERR must never count, so replies are only accepted after
    // the keyboard host has reported the command as pending.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE:       if (grant) state_d = ST_ISSUE1;
            ST_ISSUE1:     state_d = len2_q ? ST_ISSUE2 : ST_WAIT_START;
            ST_ISSUE2:     state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (kbd_stat_i == STAT_BUSY) begin
                    state_d = ST_WAIT_REPLY;
                end else if (tmo_expired) begin
                    state_d = ST_FINISH;
                    res_d   = RES_TMO;
                end
            end
            ST_WAIT_REPLY: begin
                if (kbd_stat_i == STAT_ACK) begin
                    state_d = ST_FINISH;
                    res_d   = RES_OK;
                end else if (kbd_stat_i == STAT_ERR) begin
                    state_d = ST_FINISH;
                    res_d   = RES_ERR;
                end else if (tmo_expired) begin
                    state_d = ST_FINISH;
                    res_d   = RES_TMO;
                end
            end
            ST_FINISH:     state_d = retry_due ? ST_ISSUE1 : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in the
    // same cycle the FSM enters that state.
    always_comb begin
        wcmddata_d = 8'h00;
        enq1_d     = 1'b0;
        enq2_d     = 1'b0;
        ack_d      = grant_host;
        done_d     = completes;
        done_src_d = completes && src_q;
        stat_d     = sched_stat_o;
        if (grant)
            stat_d = STAT_BUSY;
        else if (completes)
            stat_d = final_stat(res_d);
        case (state_d)
            ST_ISSUE1: begin
                wcmddata_d = cmd_n;
                enq1_d     = !len2_n;
                enq2_d     = len2_n;
            end
            ST_ISSUE2: begin
                wcmddata_d = data_q;
                enq2_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            kbd_wcmddata_o <= 8'h00;
            kbd_enq_cmd1_o <= 1'b0;
            kbd_enq_cmd2_o <= 1'b0;
            host_ack_o     <= 1'b0;
            done_o         <= 1'b0;
            done_src_o     <= 1'b0;
            sched_stat_o   <= STAT_IDLE;
        end else begin
            kbd_wcmddata_o <= wcmddata_d;
            kbd_enq_cmd1_o <= enq1_d;
            kbd_enq_cmd2_o <= enq2_d;
            host_ack_o     <= ack_d;
            done_o         <= done_d;
            done_src_o     <= done_src_d;
            sched_stat_o   <= stat_d;
        end
    end

    assign tmo_enable = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_REPLY);
    assign tmo_clear  = (state_d != state_q) &&
                        ((state_d == ST_WAIT_START) || (state_d == ST_WAIT_REPLY));

    us_timeout #(
        .TIMEOUT_US(TIMEOUT_US)
    ) u_timeout (
        .clk6x  (clk6x),
        .reset  (reset),
        .ck1us  (ck1us),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Directed bench for ps2_cmd_sched: host/init commands, arbitration,
// retries, stale-status timeout and mid-command reset.
module tb_ps2_cmd_sched;
  import ps2_cmd_sched_pkg::*;

  logic       clk6x = 1'b0;
  logic       reset = 1'b1;
  logic       ck1us = 1'b0;
  logic       host_req_i = 1'b0;
  logic       host_len2_i = 1'b0;
  logic [7:0] host_cmd_i = 8'h00;
  logic [7:0] host_data_i = 8'h00;
  logic       bat_ok_i = 1'b0;
  logic [7:0] kbd_stat_i = 8'h00;
  logic       host_ack_o;
  logic [7:0] kbd_wcmddata_o;
  logic       kbd_enq_cmd1_o;
  logic       kbd_enq_cmd2_o;
  logic [7:0] sched_stat_o;
  logic       done_o;
  logic       done_src_o;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int t5_wait = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_obs;
  logic [9:0] mon_exp;

  ps2_cmd_sched #(
    .TIMEOUT_US(5),
    .MAX_RETRY(2)
  ) dut (
    .clk6x(clk6x),
    .reset(reset),
    .ck1us(ck1us),
    .host_req_i(host_req_i),
    .host_len2_i(host_len2_i),
    .host_cmd_i(host_cmd_i),
    .host_data_i(host_data_i),
    .host_ack_o(host_ack_o),
    .bat_ok_i(bat_ok_i),
    .kbd_stat_i(kbd_stat_i),
    .kbd_wcmddata_o(kbd_wcmddata_o),
    .kbd_enq_cmd1_o(kbd_enq_cmd1_o),
    .kbd_enq_cmd2_o(kbd_enq_cmd2_o),
    .sched_stat_o(sched_stat_o),
    .done_o(done_o),
    .done_src_o(done_src_o),
    .dbg_state(dbg_state)
  );

  // clock / microsecond tick
  always #10 clk6x = ~clk6x;

  initial begin
    forever begin
      repeat (3) @(posedge clk6x);
      #1 ck1us = 1'b1;
      @(posedge clk6x);
      #1 ck1us = 1'b0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk6x);
    #1;
  endtask

  task automatic sample();
    @(negedge clk6x);
  endtask

  task automatic host_cmd(input logic len2, input logic [7:0] cmd, input logic [7:0] data);
    host_req_i  = 1'b1;
    host_len2_i = len2;
    host_cmd_i  = cmd;
    host_data_i = data;
  endtask

  task automatic exp_enq(input logic len2, input logic [7:0] cmd, input logic [7:0] data);
    if (len2) begin
      exp_q.push_back({2'b01, cmd});
      exp_q.push_back({2'b01, data});
    end else begin
      exp_q.push_back({2'b10, cmd});
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    chk8(tag, {5'b0, dbg_state}, {5'b0, exp});
  endtask

  // scoreboard: every enqueue pulse must match the next expected byte
  always @(negedge clk6x) begin
    if (!reset) begin
      if (kbd_enq_cmd1_o || kbd_enq_cmd2_o) begin
        mon_obs = {kbd_enq_cmd1_o, kbd_enq_cmd2_o, kbd_wcmddata_o};
        mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
        chk10("enq", mon_obs, mon_exp);
      end
      if (done_o) done_cnt++;
      if (host_ack_o) ack_cnt++;
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk6x);
    #1;
    sample();
    chk8("rst_stat", sched_stat_o, 8'h00);
    chk8("rst_data", kbd_wcmddata_o, 8'h00);
    chk8("rst_pulses", {3'b0, kbd_enq_cmd1_o, kbd_enq_cmd2_o, host_ack_o, done_o, done_src_o}, 8'h00);
    chk_state("rst_state", ST_IDLE);
    step();
    reset = 1'b0;
    step();

    // T1: host one-byte 0xF4, ACK
    host_cmd(1'b0, 8'hF4, 8'h00);
    exp_enq(1'b0, 8'hF4, 8'h00);
    step(); sample();
    chk1("t1_ack", host_ack_o, 1'b1);
    chk1("t1_enq1", kbd_enq_cmd1_o, 1'b1);
    chk8("t1_byte", kbd_wcmddata_o, 8'hF4);
    chk8("t1_busy", sched_stat_o, 8'h01);
    step(); host_req_i = 1'b0; kbd_stat_i = 8'h01;
    step(); kbd_stat_i = 8'hFA;
    step(); sample();
    chk1("t1_done", done_o, 1'b1);
    chk1("t1_src", done_src_o, 1'b0);
    chk8("t1_stat", sched_stat_o, 8'hFA);
    step(); sample();
    chk1("t1_done_once", done_o, 1'b0);
    chk8("t1_stat_hold", sched_stat_o, 8'hFA);
    chk_state("t1_idle", ST_IDLE);
    kbd_stat_i = 8'h00;
    chk8("t1_acks", 8'(ack_cnt), 8'd1);
    chk8("t1_dones", 8'(done_cnt), 8'd1);

    // T2: BAT -> 0xED 0x00 back to back
    bat_ok_i = 1'b1;
    exp_enq(1'b1, 8'hED, 8'h00);
    step(); bat_ok_i = 1'b0; sample();
    chk1("t2_enq2_a", kbd_enq_cmd2_o, 1'b1);
    chk8("t2_byte1", kbd_wcmddata_o, 8'hED);
    chk1("t2_no_ack", host_ack_o, 1'b0);
    chk8("t2_busy", sched_stat_o, 8'h01);
    step(); sample();
    chk1("t2_enq2_b", kbd_enq_cmd2_o, 1'b1);
    chk8("t2_byte2", kbd_wcmddata_o, 8'h00);
    step(); kbd_stat_i = 8'h01;
    step(); kbd_stat_i = 8'hFA;
    step(); sample();
    chk1("t2_done", done_o, 1'b1);
    chk1("t2_src", done_src_o, 1'b1);
    chk8("t2_stat", sched_stat_o, 8'hFA);
    step(); kbd_stat_i = 8'h00;

    // T3: BAT and host request together, init first
    bat_ok_i = 1'b1;
    host_cmd(1'b1, 8'hED, 8'h02);
    exp_enq(1'b1, 8'hED, 8'h00);
    exp_enq(1'b1, 8'hED, 8'h02);
    step(); bat_ok_i = 1'b0; sample();
    chk1("t3_init_no_ack", host_ack_o, 1'b0);
    chk8("t3_init_byte1", kbd_wcmddata_o, 8'hED);
    step(); sample();
    chk8("t3_init_byte2", kbd_wcmddata_o, 8'h00);
    step(); kbd_stat_i = 8'h01;
    step(); kbd_stat_i = 8'hFA;
    step(); sample();
    chk1("t3_init_done", done_o, 1'b1);
    chk1("t3_init_src", done_src_o, 1'b1);
    chk1("t3_ack_late", host_ack_o, 1'b0);
    kbd_stat_i = 8'h00;
    step(); sample();
    chk1("t3_idle_no_ack", host_ack_o, 1'b0);
    step(); sample();
    chk1("t3_host_ack", host_ack_o, 1'b1);
    chk8("t3_host_byte1", kbd_wcmddata_o, 8'hED);
    step(); host_req_i = 1'b0; sample();
    chk8("t3_host_byte2", kbd_wcmddata_o, 8'h02);
    step(); kbd_stat_i = 8'h01;
    step(); kbd_stat_i = 8'hFA;
    step(); sample();
    chk1("t3_host_done", done_o, 1'b1);
    chk1("t3_host_src", done_src_o, 1'b0);
    step(); kbd_stat_i = 8'h00;
    chk8("t3_acks", 8'(ack_cnt), 8'd2);
    chk8("t3_dones", 8'(done_cnt), 8'd4);

    // T4: ERR three times, retries exhausted
    host_cmd(1'b1, 8'hF3, 8'h20);
    for (int a = 0; a < 3; a++) exp_enq(1'b1, 8'hF3, 8'h20);
    for (int a = 0; a < 3; a++) begin
      step(); sample();
      chk1("t4_ack", host_ack_o, a == 0);
      chk8("t4_byte1", kbd_wcmddata_o, 8'hF3);
      step(); host_req_i = 1'b0;
      step(); kbd_stat_i = 8'h01;
      step(); kbd_stat_i = 8'hFE;
      step(); sample();
      chk1("t4_done", done_o, a == 2);
      chk8("t4_stat", sched_stat_o, (a == 2) ? 8'hFE : 8'h01);
    end
    step(); kbd_stat_i = 8'h00;
    chk8("t4_acks", 8'(ack_cnt), 8'd3);
    chk8("t4_dones", 8'(done_cnt), 8'd5);
    chk8("t4_issues", 8'(exp_q.size()), 8'd0);

    // T5: stale 0xFA, never pending -> timeout after retries
    kbd_stat_i = 8'hFA;
    host_cmd(1'b0, 8'hEE, 8'h00);
    for (int a = 0; a < 3; a++) exp_enq(1'b0, 8'hEE, 8'h00);
    step(); sample();
    chk1("t5_ack", host_ack_o, 1'b1);
    step(); host_req_i = 1'b0;
    repeat (7) step();
    sample();
    chk_state("t5_no_false_ack", ST_WAIT_START);
    chk8("t5_busy", sched_stat_o, 8'h01);
    t5_wait = 0;
    while (!done_o && t5_wait < 120) begin
      step(); sample();
      t5_wait++;
    end
    chk1("t5_done_seen", done_o, 1'b1);
    chk8("t5_stat", sched_stat_o, 8'hFF);
    chk1("t5_src", done_src_o, 1'b0);
    chk1("t5_timing", (t5_wait >= 45) && (t5_wait <= 65), 1'b1);
    step(); kbd_stat_i = 8'h00;
    chk8("t5_issues", 8'(exp_q.size()), 8'd0);
    chk8("t5_dones", 8'(done_cnt), 8'd6);

    // T6: reset during WAIT_REPLY, then normal command
    host_cmd(1'b0, 8'hF5, 8'h00);
    exp_enq(1'b0, 8'hF5, 8'h00);
    step(); sample();
    chk1("t6_ack", host_ack_o, 1'b1);
    step(); host_req_i = 1'b0; kbd_stat_i = 8'h01;
    step();
    step(); sample();
    chk_state("t6_wait_reply", ST_WAIT_REPLY);
    #2 reset = 1'b1;
    #1;
    chk8("t6_rst_stat", sched_stat_o, 8'h00);
    chk8("t6_rst_pulses", {3'b0, kbd_enq_cmd1_o, kbd_enq_cmd2_o, host_ack_o, done_o, done_src_o}, 8'h00);
    chk_state("t6_rst_state", ST_IDLE);
    step(); step();
    reset = 1'b0;
    kbd_stat_i = 8'h00;
    chk8("t6_no_done", 8'(done_cnt), 8'd6);
    host_cmd(1'b0, 8'hF6, 8'h00);
    exp_enq(1'b0, 8'hF6, 8'h00);
    step(); sample();
    chk1("t6_ack2", host_ack_o, 1'b1);
    chk8("t6_byte", kbd_wcmddata_o, 8'hF6);
    step(); host_req_i = 1'b0; kbd_stat_i = 8'h01;
    step(); kbd_stat_i = 8'hFA;
    step(); sample();
    chk1("t6_done", done_o, 1'b1);
    chk8("t6_stat", sched_stat_o, 8'hFA);
    step(); kbd_stat_i = 8'h00;
    chk8("t6_acks", 8'(ack_cnt), 8'd6);
    chk8("t6_dones", 8'(done_cnt), 8'd7);
    chk8("final_issues", 8'(exp_q.size()), 8'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
